// File: rtl/axis_dw_shift.sv
// axis_dw_shift: AXI-Stream width down-converter. One wide beat of MEMBERS
// members is registered, then emitted one member per output beat in ascending
// member index, skipping members whose keep bit is clear (or emitting them
// with zeroed data when ZERO=1). The per-member user word passes through.
// Optional feature macro: AXIS_DW_SHIFT_IDX_EN adds the m_idx output port.
module axis_dw_shift #(
  parameter int ZERO         = 0,
  parameter int WORD_WIDTH   = 8,
  parameter int UNITS        = 2,
  parameter int MEMBERS      = 24,
  parameter int KW_MAX       = 11,
  parameter int SW_MAX       = 4,
  parameter int I_KW2        = 2,
  parameter int BITS_KW2     = $clog2(KW_MAX/2+1),
  parameter int I_SW_1       = I_KW2+BITS_KW2,
  parameter int BITS_SW      = $clog2(SW_MAX+1),
  parameter int TUSER_WIDTH  = 8,
  parameter int BITS_MEMBERS = $clog2(MEMBERS)
) (
  input  logic                                            aclk,
  input  logic                                            areset,
  input  logic                                            s_valid,
  output logic                                            s_ready,
  input  logic                                            s_last,
  input  logic [MEMBERS-1:0][UNITS-1:0][WORD_WIDTH-1:0]   s_data,
  input  logic [MEMBERS-1:0]                              s_keep,
  input  logic [MEMBERS-1:0][TUSER_WIDTH-1:0]             s_user,
  input  logic                                            m_ready,
  output logic                                            m_valid,
  output logic                                            m_last,
  output logic [UNITS-1:0][WORD_WIDTH-1:0]                m_data,
`ifdef AXIS_DW_SHIFT_IDX_EN
  output logic [BITS_MEMBERS-1:0]                         m_idx,
`endif
  output logic [TUSER_WIDTH-1:0]                          m_user
);

  // The user word must hold the kw/2 and sw-1 fields; the index must cover all members.
  if ((TUSER_WIDTH < I_SW_1 + BITS_SW) || ((1 << BITS_MEMBERS) < MEMBERS)) begin : g_cfg_err
    $error("axis_dw_shift: TUSER_WIDTH or BITS_MEMBERS too small");
  end

  localparam logic [MEMBERS-1:0] ONE = MEMBERS'(1);

  logic [MEMBERS-1:0]                            pend_q, pend_d;
  logic [MEMBERS-1:0]                            keep_q, keep_d;
  logic                                          last_q, last_d;
  logic [MEMBERS-1:0][UNITS-1:0][WORD_WIDTH-1:0] data_q, data_d;
  logic [MEMBERS-1:0][TUSER_WIDTH-1:0]           user_q, user_d;

  logic [MEMBERS-1:0] cur_oh;
  logic               pend_onehot;
  logic               in_fire;
  logic               out_fire;

  // Lowest pending member isolated as a one-hot vector; drives the output mux.
  assign cur_oh      = pend_q & (~pend_q + ONE);
  assign pend_onehot = (pend_q != '0) && ((pend_q & (pend_q - ONE)) == '0);

  assign m_valid  = |pend_q;
  assign m_last   = last_q & pend_onehot;
  // Accept a new beat when empty, or when the final pending member leaves this cycle.
  assign s_ready  = !areset & ((pend_q == '0) | (pend_onehot & m_ready));
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;

  // AND-OR output mux over the one-hot selection; unkept members read as zero data.
  always_comb begin
    m_data = '0;
    m_user = '0;
    for (int i = 0; i < MEMBERS; i++) begin
      if (cur_oh[i]) begin
        m_user = user_q[i];
        if ((ZERO == 0) || keep_q[i]) begin
          m_data = data_q[i];
        end
      end
    end
  end

`ifdef AXIS_DW_SHIFT_IDX_EN
  // Binary index of the currently presented member.
  always_comb begin
    m_idx = '0;
    for (int i = 0; i < MEMBERS; i++) begin
      if (cur_oh[i]) begin
        m_idx = BITS_MEMBERS'(i);
      end
    end
  end
`endif

  // Next state: retire the presented member, then a load overrides everything.
  always_comb begin
    pend_d = pend_q;
    keep_d = keep_q;
    last_d = last_q;
    data_d = data_q;
    user_d = user_q;
    if (out_fire) begin
      pend_d = pend_q & ~cur_oh;
    end
    if (in_fire) begin
      pend_d = (ZERO != 0) ? '1 : s_keep;
      keep_d = s_keep;
      last_d = s_last;
      data_d = s_data;
      user_d = s_user;
    end
  end

  // Control state: pending mask and packet-end flag, cleared by reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pend_q <= '0;
      last_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end

  // Payload registers: no reset, only meaningful while a pending bit is set.
  always_ff @(posedge aclk) begin
    keep_q <= keep_d;
    data_q <= data_d;
    user_q <= user_d;
  end

endmodule

// File: tb/tb_axis_dw_shift.sv
// Directed self-checking bench for axis_dw_shift (default parameters, ZERO=0).
module tb_axis_dw_shift;

  localparam int M  = 24;
  localparam int U  = 2;
  localparam int W  = 8;
  localparam int UW = 8;

  logic                         aclk = 1'b0;
  logic                         areset = 1'b1;
  logic                         s_valid = 1'b0;
  logic                         s_ready;
  logic                         s_last = 1'b0;
  logic [M-1:0][U-1:0][W-1:0]   s_data = '0;
  logic [M-1:0]                 s_keep = '0;
  logic [M-1:0][UW-1:0]         s_user = '0;
  logic                         m_ready = 1'b0;
  logic                         m_valid;
  logic                         m_last;
  logic [U-1:0][W-1:0]          m_data;
  logic [UW-1:0]                m_user;
`ifdef AXIS_DW_SHIFT_IDX_EN
  logic [4:0]                   m_idx;
`endif

  int total = 0;
  int bad   = 0;

  axis_dw_shift dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_user  (s_user),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_data  (m_data),
`ifdef AXIS_DW_SHIFT_IDX_EN
    .m_idx   (m_idx),
`endif
    .m_user  (m_user)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Data pattern s_data[m][u] = m*10+u+1; user word = m + uoff.
  task automatic present(input logic [M-1:0] keep, input logic last, input int uoff);
    for (int m = 0; m < M; m++) begin
      for (int u = 0; u < U; u++) s_data[m][u] = W'(m*10 + u + 1);
      s_user[m] = UW'(m + uoff);
    end
    s_keep  = keep;
    s_last  = last;
    s_valid = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input int m);
    return 32'(((m*10 + 2) << 8) | (m*10 + 1));
  endfunction

  initial begin
    logic [M-1:0] odd_keep;
    int exp_m;
    int cyc;
    for (int m = 0; m < M; m++) odd_keep[m] = (m % 2 == 1);

    // Reset state
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last",  32'(m_last), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    areset = 1'b0;
    #1;
    check("idle_s_ready", 32'(s_ready), 1);
    check("idle_m_valid", 32'(m_valid), 0);

    // 1. Full beat, no backpressure
    m_ready = 1'b1;
    present('1, 1'b1, 100);
    tick();
    s_valid = 1'b0;
    for (int m = 0; m < M; m++) begin
      check("t1_valid",  32'(m_valid), 1);
      check("t1_data",   32'(m_data), exp_data(m));
      check("t1_user",   32'(m_user), 32'(m + 100));
      check("t1_last",   32'(m_last), 32'(m == 23));
      check("t1_sready", 32'(s_ready), 32'(m == 23));
      $display("t1 member %0d data=%0d", m, m_data);
      tick();
    end
    check("t1_drained", 32'(m_valid), 0);

    // 2. Sparse keep, odd members only
    present(odd_keep, 1'b1, 0);
    tick();
    s_valid = 1'b0;
    for (int m = 1; m < M; m += 2) begin
      check("t2_valid", 32'(m_valid), 1);
      check("t2_data",  32'(m_data), exp_data(m));
      check("t2_user",  32'(m_user), 32'(m));
      check("t2_last",  32'(m_last), 32'(m == 23));
`ifdef AXIS_DW_SHIFT_IDX_EN
      check("t6_idx",   32'(m_idx), 32'(m));
`endif
      $display("t2 member %0d data=%0d", m, m_data);
      tick();
    end
    check("t2_drained", 32'(m_valid), 0);

    // 3. Backpressure: 3 stalled cycles, then alternate ready on/off
    m_ready = 1'b0;
    present('1, 1'b1, 30);
    tick();
    s_valid = 1'b0;
    exp_m = 0;
    cyc = 0;
    while (exp_m < M && cyc < 200) begin
      m_ready = (cyc < 3) ? 1'b0 : (((cyc - 3) % 2) == 0);
      #1;
      check("t3_valid",  32'(m_valid), 1);
      check("t3_data",   32'(m_data), exp_data(exp_m));
      check("t3_user",   32'(m_user), 32'(exp_m + 30));
      check("t3_last",   32'(m_last), 32'(exp_m == 23));
      check("t3_sready", 32'(s_ready), 32'((exp_m == 23) && m_ready));
      $display("t3 cycle %0d member %0d ready=%0d", cyc, exp_m, m_ready);
      tick();
      if (m_ready) exp_m++;
      cyc++;
    end
    check("t3_budget", 32'(exp_m), 32'(M));
    m_ready = 1'b1;
    #1;
    check("t3_drained", 32'(m_valid), 0);

    // 4. Back-to-back beats with s_valid held
    present(24'h000024, 1'b0, 0);          // members 2 and 5
    tick();
    present(24'h000081, 1'b1, 50);         // members 0 and 7, distinct user
    check("t4_a2_data",   32'(m_data), exp_data(2));
    check("t4_a2_sready", 32'(s_ready), 0);
    tick();
    check("t4_a5_data",   32'(m_data), exp_data(5));
    check("t4_a5_user",   32'(m_user), 5);
    check("t4_a5_last",   32'(m_last), 0);
    check("t4_a5_sready", 32'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    check("t4_b0_valid", 32'(m_valid), 1);
    check("t4_b0_data",  32'(m_data), exp_data(0));
    check("t4_b0_user",  32'(m_user), 50);
    check("t4_b0_last",  32'(m_last), 0);
    tick();
    check("t4_b7_data",  32'(m_data), exp_data(7));
    check("t4_b7_user",  32'(m_user), 57);
    check("t4_b7_last",  32'(m_last), 1);
    $display("t4 back-to-back done");
    tick();
    check("t4_drained", 32'(m_valid), 0);

    // 5a. Empty keep with s_last: nothing emitted
    present('0, 1'b1, 0);
    tick();
    s_valid = 1'b0;
    check("t5_empty_valid",  32'(m_valid), 0);
    check("t5_empty_last",   32'(m_last), 0);
    check("t5_empty_sready", 32'(s_ready), 1);
    tick();
    check("t5_empty_valid2", 32'(m_valid), 0);
    $display("t5 empty keep done");

    // 5b. Reset mid-drain, then a fresh beat starts at member 0
    present('1, 1'b1, 0);
    tick();
    s_valid = 1'b0;
    tick();
    check("t5_pre_rst_data", 32'(m_data), exp_data(1));
    areset = 1'b1;
    #1;
    check("t5_rst_sready", 32'(s_ready), 0);
    tick();
    check("t5_rst_valid", 32'(m_valid), 0);
    check("t5_rst_last",  32'(m_last), 0);
    areset = 1'b0;
    present('1, 1'b1, 77);
    tick();
    s_valid = 1'b0;
    for (int m = 0; m < M; m++) begin
      check("t5_post_valid", 32'(m_valid), 1);
      check("t5_post_data",  32'(m_data), exp_data(m));
      check("t5_post_user",  32'(m_user), 32'(m + 77));
      check("t5_post_last",  32'(m_last), 32'(m == 23));
      tick();
    end
    check("t5_post_drained", 32'(m_valid), 0);
    $display("t5 reset mid-drain done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
